// File: rtl/aemb_bus_pkg.sv
// Shared definitions for the aeMB two-master bus arbiter.
//   arb_state_e : arbiter FSM encoding (IDLE / IGNT / DGNT)
//   MST_IWB/DWB : master identifiers as stored in the last-grant register
//   TMO_DEFAULT : default watchdog limit in cycles from grant to ack
package aemb_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } arb_state_e;

  localparam logic MST_IWB = 1'b0;
  localparam logic MST_DWB = 1'b1;

  localparam int TMO_DEFAULT = 255;

endpackage

// File: rtl/aemb_bus_wdog.sv
// Grant watchdog for the aeMB bus arbiter.
// Counts granted cycles that pass without an acknowledge and flags expiry
// when the count reaches TMO-1 with still no ack.
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset
//   clr    : clear the count (asserted on the cycle a grant is issued)
//   run    : granted, owner strobing, no ack this cycle
//   expire : combinational expiry, forces the arbiter back to IDLE
//   tmo    : registered one-cycle expiry pulse
module aemb_bus_wdog
  import aemb_bus_pkg::*;
#(
  parameter int TMO = TMO_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic expire,
  output logic tmo
);

  localparam logic [7:0] LIMIT = 8'(TMO - 1);

  logic [7:0] cnt;

  assign expire = run & (cnt == LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 8'd0;
      tmo <= 1'b0;
    end else begin
      tmo <= expire;
      if (clr) begin
        cnt <= 8'd0;
      end else if (run) begin
        cnt <= cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/aemb_bus_arb.sv
// Two-master (fetch iwb / data dwb) to one-slave (mwb) round-robin arbiter.
// Ports:
//   sys_clk_i, sys_rst_i       : clock, synchronous active-high reset
//   iwb_*                      : fetch master (read only)
//   dwb_*                      : data master (read/write, byte lanes)
//   mwb_*                      : shared slave port
//   arb_tmo_o                  : one-cycle watchdog-expiry pulse
//   dbg_state                  : current arbiter FSM state
// Handshake: a master holds stb and its request fields stable until its ack;
// ack is mwb_ack_i routed combinationally to the current owner only, and a
// transfer completes in the cycle where owner stb and ack are both high.
module aemb_bus_arb
  import aemb_bus_pkg::*;
#(
  parameter int AW  = 16,
  parameter int TMO = TMO_DEFAULT
) (
  input  logic          sys_clk_i,
  input  logic          sys_rst_i,
  input  logic [AW-1:2] iwb_adr_i,
  input  logic          iwb_stb_i,
  output logic [31:0]   iwb_dat_o,
  output logic          iwb_ack_o,
  input  logic [AW-1:2] dwb_adr_i,
  input  logic          dwb_stb_i,
  input  logic          dwb_wre_i,
  input  logic [3:0]    dwb_sel_i,
  input  logic [31:0]   dwb_dat_i,
  output logic [31:0]   dwb_dat_o,
  output logic          dwb_ack_o,
  output logic [AW-1:2] mwb_adr_o,
  output logic          mwb_stb_o,
  output logic          mwb_wre_o,
  output logic [3:0]    mwb_sel_o,
  output logic [31:0]   mwb_dat_o,
  input  logic [31:0]   mwb_dat_i,
  input  logic          mwb_ack_i,
  output logic          arb_tmo_o,
  output logic [1:0]    dbg_state
);

  arb_state_e state, state_nxt;
  logic       last;
  logic       grant_start;
  logic       wdog_run;
  logic       wdog_expire;

  // state register
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state <= IDLE;
      last  <= MST_DWB;     // iwb wins the first tie after reset
    end else begin
      state <= state_nxt;
      if (grant_start) begin
        last <= (state_nxt == DGNT) ? MST_DWB : MST_IWB;
      end
    end
  end

  // next-state logic; every granted state releases through IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (iwb_stb_i && dwb_stb_i) begin
          state_nxt = (last == MST_DWB) ? IGNT : DGNT;
        end else if (iwb_stb_i) begin
          state_nxt = IGNT;
        end else if (dwb_stb_i) begin
          state_nxt = DGNT;
        end
      end
      IGNT: begin
        if (!iwb_stb_i || mwb_ack_i || wdog_expire) state_nxt = IDLE;
      end
      DGNT: begin
        if (!dwb_stb_i || mwb_ack_i || wdog_expire) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // output mux
  always_comb begin
    mwb_adr_o = '0;
    mwb_wre_o = 1'b0;
    mwb_sel_o = 4'h0;
    mwb_dat_o = 32'h0;
    case (state)
      IGNT: begin
        mwb_adr_o = iwb_adr_i;
        mwb_sel_o = 4'hF;     // fetches are always full-word reads
      end
      DGNT: begin
        mwb_adr_o = dwb_adr_i;
        mwb_wre_o = dwb_wre_i;
        mwb_sel_o = dwb_sel_i;
        mwb_dat_o = dwb_dat_i;
      end
      default: ;
    endcase
  end

  assign mwb_stb_o = ((state == IGNT) & iwb_stb_i) | ((state == DGNT) & dwb_stb_i);
  assign iwb_ack_o = (state == IGNT) & mwb_ack_i & iwb_stb_i;
  assign dwb_ack_o = (state == DGNT) & mwb_ack_i & dwb_stb_i;
  assign iwb_dat_o = mwb_dat_i;
  assign dwb_dat_o = mwb_dat_i;
  assign dbg_state = state;

  assign grant_start = (state == IDLE) & (state_nxt != IDLE);
  // an aborting owner (stb low) releases without counting as a timeout
  assign wdog_run    = mwb_stb_o & ~mwb_ack_i;

  aemb_bus_wdog #(
    .TMO (TMO)
  ) u_wdog (
    .clk    (sys_clk_i),
    .rst    (sys_rst_i),
    .clr    (grant_start),
    .run    (wdog_run),
    .expire (wdog_expire),
    .tmo    (arb_tmo_o)
  );

endmodule

// File: tb/tb_aemb_bus_arb.sv
// Self-checking bench for aemb_bus_arb (AW = 16, TMO = 4).
// A behavioural slave acks after a programmable wait; expected acks
// {master, data} are queued when requests are issued and popped when an ack
// appears on either master port.
module tb_aemb_bus_arb;

  localparam int AW  = 16;
  localparam int TMO = 4;

  logic          sys_clk_i = 1'b0;
  logic          sys_rst_i;
  logic [AW-1:2] iwb_adr_i;
  logic          iwb_stb_i;
  logic [31:0]   iwb_dat_o;
  logic          iwb_ack_o;
  logic [AW-1:2] dwb_adr_i;
  logic          dwb_stb_i;
  logic          dwb_wre_i;
  logic [3:0]    dwb_sel_i;
  logic [31:0]   dwb_dat_i;
  logic [31:0]   dwb_dat_o;
  logic          dwb_ack_o;
  logic [AW-1:2] mwb_adr_o;
  logic          mwb_stb_o;
  logic          mwb_wre_o;
  logic [3:0]    mwb_sel_o;
  logic [31:0]   mwb_dat_o;
  logic [31:0]   mwb_dat_i;
  logic          mwb_ack_i;
  logic          arb_tmo_o;
  logic [1:0]    dbg_state;

  aemb_bus_arb #(.AW(AW), .TMO(TMO)) dut (
    .sys_clk_i (sys_clk_i),
    .sys_rst_i (sys_rst_i),
    .iwb_adr_i (iwb_adr_i),
    .iwb_stb_i (iwb_stb_i),
    .iwb_dat_o (iwb_dat_o),
    .iwb_ack_o (iwb_ack_o),
    .dwb_adr_i (dwb_adr_i),
    .dwb_stb_i (dwb_stb_i),
    .dwb_wre_i (dwb_wre_i),
    .dwb_sel_i (dwb_sel_i),
    .dwb_dat_i (dwb_dat_i),
    .dwb_dat_o (dwb_dat_o),
    .dwb_ack_o (dwb_ack_o),
    .mwb_adr_o (mwb_adr_o),
    .mwb_stb_o (mwb_stb_o),
    .mwb_wre_o (mwb_wre_o),
    .mwb_sel_o (mwb_sel_o),
    .mwb_dat_o (mwb_dat_o),
    .mwb_dat_i (mwb_dat_i),
    .mwb_ack_i (mwb_ack_i),
    .arb_tmo_o (arb_tmo_o),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset / global bound
  always #5 sys_clk_i = ~sys_clk_i;

  int cyc = 0;
  always @(posedge sys_clk_i) cyc = cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time bound expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- behavioural slave
  logic [31:0] slave_base;
  int          slave_lat;
  logic        never_ack;
  logic        stray_ack;
  int          wcnt = 0;

  assign mwb_dat_i = slave_base ^ {18'h0, mwb_adr_o};

  always @(posedge sys_clk_i) begin
    #2;
    mwb_ack_i = stray_ack;
    if (mwb_stb_o) begin
      if (!never_ack && wcnt == slave_lat) begin
        mwb_ack_i = 1'b1;
        wcnt = 0;
      end else begin
        wcnt = wcnt + 1;
      end
    end else begin
      wcnt = 0;
    end
  end

  // ---------------- scoreboard
  logic [32:0] exp_q[$];
  logic [32:0] exp_e;
  logic        owner;

  always @(negedge sys_clk_i) begin
    if (!sys_rst_i) begin
      if (mwb_stb_o && exp_q.size() > 0) begin
        owner = exp_q[0][32];
        if (owner) begin
          check("bus_adr_d", mwb_adr_o, dwb_adr_i);
          check("bus_wre_d", mwb_wre_o, dwb_wre_i);
          check("bus_sel_d", mwb_sel_o, dwb_sel_i);
          check("bus_dat_d", mwb_dat_o, dwb_dat_i);
        end else begin
          check("bus_adr_i", mwb_adr_o, iwb_adr_i);
          check("bus_wre_i", mwb_wre_o, 1'b0);
          check("bus_sel_i", mwb_sel_o, 4'hF);
          check("bus_dat_i", mwb_dat_o, 32'h0);
        end
      end
      if (iwb_ack_o || dwb_ack_o) begin
        if (exp_q.size() == 0) begin
          check("unexp_ack", {iwb_ack_o, dwb_ack_o}, 2'b00);
        end else begin
          exp_e = exp_q.pop_front();
          check("ack_id", {iwb_ack_o, dwb_ack_o}, exp_e[32] ? 2'b01 : 2'b10);
          check("ack_dat", exp_e[32] ? dwb_dat_o : iwb_dat_o, exp_e[31:0]);
        end
      end
    end
  end

  // ---------------- driver tasks
  task automatic tick();
    @(posedge sys_clk_i);
    #1;
  endtask

  logic [AW-1:2] snap_adr;
  logic          snap_wre;
  logic [3:0]    snap_sel;
  logic [31:0]   snap_dat;
  int            rise_cyc;
  int            ack_cyc;

  // single-master transfer; call right after tick()
  task automatic xfer(input logic m, input string tag);
    bit got = 0;
    rise_cyc = -1;
    ack_cyc  = -1;
    if (m) dwb_stb_i = 1'b1; else iwb_stb_i = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge sys_clk_i);
      if (mwb_stb_o) begin
        if (rise_cyc < 0) rise_cyc = cyc;
        snap_adr = mwb_adr_o;
        snap_wre = mwb_wre_o;
        snap_sel = mwb_sel_o;
        snap_dat = mwb_dat_o;
      end
      if (m ? dwb_ack_o : iwb_ack_o) begin
        got = 1;
        ack_cyc = cyc;
      end
    end
    check({tag, "_done"}, got, 1'b1);
    tick();
    iwb_stb_i = 1'b0;
    dwb_stb_i = 1'b0;
    @(negedge sys_clk_i);
    check({tag, "_one_ack"}, {iwb_ack_o, dwb_ack_o}, 2'b00);
  endtask

  // both masters strobing; n alternating grants starting with iwb
  task automatic run_both(input int n, input string tag);
    int ack_n = 0;
    int prev  = -1;
    for (int k = 0; k < n; k++) begin
      exp_q.push_back((k % 2 == 0) ? {1'b0, slave_base ^ {18'h0, iwb_adr_i}}
                                   : {1'b1, slave_base ^ {18'h0, dwb_adr_i}});
    end
    iwb_stb_i = 1'b1;
    dwb_stb_i = 1'b1;
    for (int i = 0; i < 40 && ack_n < n; i++) begin
      @(negedge sys_clk_i);
      if (iwb_ack_o || dwb_ack_o) begin
        if (prev >= 0) check({tag, "_spacing"}, cyc - prev, 2);
        prev = cyc;
        ack_n++;
      end
    end
    check({tag, "_count"}, ack_n, n);
    tick();
    iwb_stb_i = 1'b0;
    dwb_stb_i = 1'b0;
  endtask

  task automatic wait_stb(input string tag);
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge sys_clk_i);
      if (mwb_stb_o) seen = 1;
    end
    check(tag, seen, 1'b1);
  endtask

  // ---------------- main sequence
  logic stb_log [0:11];
  logic tmo_log [0:11];
  int   iack_seen;

  initial begin
    sys_rst_i  = 1'b1;
    iwb_adr_i  = '0;
    iwb_stb_i  = 1'b0;
    dwb_adr_i  = '0;
    dwb_stb_i  = 1'b0;
    dwb_wre_i  = 1'b0;
    dwb_sel_i  = 4'h0;
    dwb_dat_i  = 32'h0;
    mwb_ack_i  = 1'b0;
    slave_base = 32'hC0DE_0000;
    slave_lat  = 0;
    never_ack  = 1'b0;
    stray_ack  = 1'b0;

    // reset state
    repeat (2) @(posedge sys_clk_i);
    @(negedge sys_clk_i);
    check("rst_stb", mwb_stb_o, 1'b0);
    check("rst_adr", mwb_adr_o, 14'h0);
    check("rst_sel", mwb_sel_o, 4'h0);
    check("rst_dat", mwb_dat_o, 32'h0);
    check("rst_wre", mwb_wre_o, 1'b0);
    check("rst_acks", {iwb_ack_o, dwb_ack_o}, 2'b00);
    check("rst_tmo", arb_tmo_o, 1'b0);
    check("rst_idat", iwb_dat_o, 32'hC0DE_0000);
    check("rst_ddat", dwb_dat_o, 32'hC0DE_0000);
    check("rst_state", dbg_state, 2'd0);

    // contention straight out of reset: I, D, I, D, zero-wait slave
    tick();
    sys_rst_i = 1'b0;
    iwb_adr_i = 14'h0020;
    dwb_adr_i = 14'h0030;
    dwb_sel_i = 4'hF;
    dwb_dat_i = 32'h1111_2222;
    run_both(4, "rr");
    repeat (2) tick();
    check("rr_drained", exp_q.size(), 0);

    // lone fetch, slave acks 2 cycles after stb rises
    slave_base = 32'hB000_0010;
    slave_lat  = 2;
    iwb_adr_i  = 14'h0010;
    exp_q.push_back({1'b0, 32'hB000_0000});
    xfer(1'b0, "fetch");
    check("fetch_lat", ack_cyc - rise_cyc, 2);
    check("fetch_wre", snap_wre, 1'b0);
    check("fetch_sel", snap_sel, 4'hF);
    check("fetch_drained", exp_q.size(), 0);

    // data byte write
    tick();
    slave_base = 32'h5A5A_0000;
    slave_lat  = 1;
    dwb_adr_i  = 14'h0100;
    dwb_wre_i  = 1'b1;
    dwb_sel_i  = 4'h2;
    dwb_dat_i  = 32'h0000_AB00;
    exp_q.push_back({1'b1, 32'h5A5A_0100});
    xfer(1'b1, "wr");
    check("wr_lat", ack_cyc - rise_cyc, 1);
    check("wr_adr", snap_adr, 14'h0100);
    check("wr_wre", snap_wre, 1'b1);
    check("wr_sel", snap_sel, 4'h2);
    check("wr_dat", snap_dat, 32'h0000_AB00);
    check("wr_drained", exp_q.size(), 0);

    // abort: dwb drops stb before any ack, then a stray ack in IDLE
    tick();
    dwb_wre_i = 1'b0;
    dwb_adr_i = 14'h0200;
    slave_lat = 3;
    dwb_stb_i = 1'b1;
    wait_stb("abort_grant");
    tick();
    dwb_stb_i = 1'b0;
    @(negedge sys_clk_i);
    check("abort_stb_fall", mwb_stb_o, 1'b0);
    check("abort_still_dgnt", dbg_state, 2'd2);
    @(negedge sys_clk_i);
    check("abort_idle", dbg_state, 2'd0);
    tick();
    stray_ack = 1'b1;
    @(negedge sys_clk_i);
    check("abort_stray", {iwb_ack_o, dwb_ack_o}, 2'b00);
    tick();
    stray_ack = 1'b0;

    // watchdog: fetch never acked, TMO = 4
    never_ack = 1'b1;
    iwb_adr_i = 14'h0040;
    iack_seen = 0;
    iwb_stb_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge sys_clk_i);
      stb_log[i] = mwb_stb_o;
      tmo_log[i] = arb_tmo_o;
      if (iwb_ack_o) iack_seen++;
    end
    for (int i = 0; i < 11; i++) begin
      check($sformatf("wdog_stb_%0d", i), stb_log[i],
            (i >= 1) && ((i - 1) % (TMO + 1) != TMO));
      check($sformatf("wdog_tmo_%0d", i), tmo_log[i],
            (i >= 1) && ((i - 1) % (TMO + 1) == TMO));
    end
    check("wdog_no_ack", iack_seen, 0);
    tick();
    iwb_stb_i = 1'b0;
    repeat (2) tick();
    never_ack = 1'b0;

    // reset during a data grant
    never_ack = 1'b1;
    dwb_adr_i = 14'h0300;
    dwb_stb_i = 1'b1;
    wait_stb("rstg_grant");
    tick();
    sys_rst_i = 1'b1;
    @(negedge sys_clk_i);
    check("rstg_before_edge", mwb_stb_o, 1'b1);
    tick();
    stray_ack = 1'b1;
    iwb_stb_i = 1'b1;
    @(negedge sys_clk_i);
    check("rstg_stb", mwb_stb_o, 1'b0);
    check("rstg_acks", {iwb_ack_o, dwb_ack_o}, 2'b00);
    check("rstg_state", dbg_state, 2'd0);
    tick();
    stray_ack = 1'b0;
    never_ack = 1'b0;
    slave_lat = 0;
    sys_rst_i = 1'b0;
    run_both(2, "rstg_tie");
    repeat (3) tick();
    check("final_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/aemb_bus_arb.md
# aemb_bus_arb

Two-master, one-slave bus arbiter for the aeMB EDK32 core. It merges the instruction fetch bus (iwb) and the data bus (dwb) onto a single shared memory port (mwb), so one single-ported RAM can serve a core built around a unified instruction/data memory. Arbitration is round-robin, and a watchdog releases the bus if the slave never acknowledges.

## Interface
Parameters:
- AW, 16, byte-address width; all address ports are [AW-1:2] (word address).
- TMO, 255, watchdog limit in cycles from grant to ack; 8-bit counter; legal range 1..255.

Ports:
- sys_clk_i  in  1  clock, all logic on rising edge.
- sys_rst_i  in  1  reset, synchronous, active-high.
- iwb_adr_i  in  AW-2  fetch word address.
- iwb_stb_i  in  1  fetch request.
- iwb_dat_o  out  32  fetch data, equal to mwb_dat_i.
- iwb_ack_o  out  1  fetch acknowledge.
- dwb_adr_i  in  AW-2  data word address.
- dwb_stb_i  in  1  data request.
- dwb_wre_i  in  1  data write enable.
- dwb_sel_i  in  4  data byte lanes.
- dwb_dat_i  in  32  write data.
- dwb_dat_o  out  32  read data, equal to mwb_dat_i.
- dwb_ack_o  out  1  data acknowledge.
- mwb_adr_o  out  AW-2  shared address.
- mwb_stb_o  out  1  shared strobe.
- mwb_wre_o  out  1  shared write enable.
- mwb_sel_o  out  4  shared byte lanes.
- mwb_dat_o  out  32  shared write data.
- mwb_dat_i  in  32  shared read data.
- mwb_ack_i  in  1  shared acknowledge.
- arb_tmo_o  out  1  one-cycle watchdog-expiry pulse.

## Operation
- FSM states: IDLE, IGNT, DGNT. Registers: state, rLAST (last granted master: 0 = iwb, 1 = dwb), rCNT[7:0], rTMO.
- IDLE, next-state decision:
  - Only iwb_stb_i asserted: go to IGNT.
  - Only dwb_stb_i asserted: go to DGNT.
  - Both asserted: grant the master not equal to rLAST.
  - Neither asserted: stay in IDLE.
- On entering IGNT or DGNT: rLAST updates to the granted master and rCNT clears to 0.
- Granted state, mux control:
  - Address, sel, wre and write data come from the owner.
  - In IGNT: mwb_wre_o = 0, mwb_sel_o = 4'hF, mwb_dat_o = 0.
  - In IDLE: mwb_adr_o, mwb_sel_o and mwb_dat_o are 0.
- mwb_stb_o = (state == IGNT & iwb_stb_i) | (state == DGNT & dwb_stb_i). This is combinational.
- Acknowledge routing (combinational):
  - iwb_ack_o = (state == IGNT) & mwb_ack_i & iwb_stb_i.
  - dwb_ack_o = (state == DGNT) & mwb_ack_i & dwb_stb_i.
  - A mwb_ack_i that arrives in IDLE is ignored.
- Release conditions, all returning to IDLE on the next edge:
  - Owner acked.
  - Owner drops stb without an ack (abort).
  - Watchdog expiry.
- After release, arbitration always passes through IDLE for one cycle.
- Watchdog:
  - rCNT increments each granted cycle without an ack.
  - When rCNT == TMO-1 and there is no ack: next state is IDLE, rTMO = 1 for one cycle, and the owner receives no ack.
  - A master still strobing re-arbitrates normally.
- Reset:
  - state = IDLE, rLAST = 1 (iwb wins the first tie), rCNT = 0, rTMO = 0.
  - All outputs are therefore 0, except the dat_o ports, which mirror mwb_dat_i.
  - Reset asserted mid-grant drops mwb_stb_o in the cycle after the reset edge. A late slave ack is then ignored.

## Timing
- Grant latency: a request seen at edge n puts the FSM in the granted state after edge n, so mwb_stb_o is high in cycle n+1.
- Ack path: mwb_ack_i to xwb_ack_o is zero-cycle combinational.
- Minimum cost per transfer: 1 idle cycle plus 1 slave cycle, i.e. 2 cycles for a zero-wait-state slave.
- Read data passes through combinationally, so the slave's data must be valid while it drives ack.
- Masters must hold adr/sel/wre/dat stable while stb is high and no ack has arrived.
- Under sustained contention, grants strictly alternate: I, D, I, D.

## Structure
- Shared package aemb_bus_pkg (the package is the place for shared definitions):
  - State encoding constants: IDLE = 2'd0, IGNT = 2'd1, DGNT = 2'd2.
  - Master ID constants.
  - The default TMO value.
- Natural sub-module: aemb_bus_wdog, the 8-bit grant watchdog counter producing the expiry strobe. Everything else is a single module.

## Test plan
- Lone fetch:
  - Stimulus: iwb_stb_i = 1 with adr 14'h0010; slave acks 2 cycles after mwb_stb_o rises with mwb_dat_i = 32'hB0000000.
  - Required: iwb_ack_o is high for 1 cycle with iwb_dat_o = 32'hB0000000; dwb_ack_o stays 0; mwb_wre_o = 0 and mwb_sel_o = 4'hF during the grant.
- Data byte write:
  - Stimulus: dwb_stb_i = 1, wre = 1, sel = 4'h2, dat = 32'h0000AB00, adr 14'h0100.
  - Required: the mwb outputs mirror these values exactly; dwb_ack_o pulses once.
- Simultaneous requests from reset:
  - Stimulus: both masters strobe continuously; zero-wait slave.
  - Required: grant order I, D, I, D; each ack 2 cycles apart; no master starves.
- Abort:
  - Stimulus: dwb granted, then dwb_stb_i is dropped before any ack.
  - Required: mwb_stb_o falls the same cycle; FSM is in IDLE next cycle; a later stray mwb_ack_i produces no dwb_ack_o.
- Watchdog:
  - Stimulus: TMO = 4; slave never acks a fetch.
  - Required: arb_tmo_o pulses for 1 cycle, in the cycle after the grant's 4th cycle; no iwb_ack_o; the fetch is re-granted 1 cycle later.
- Reset mid-grant:
  - Stimulus: assert sys_rst_i during DGNT.
  - Required: mwb_stb_o = 0 and all acks 0 from the next cycle; after release, iwb wins the first tie.
